// File: rtl/ntt_sched.sv
// NTT/INTT butterfly address and twiddle scheduler: 7 layers x 128 butterflies, writes delayed by PIPE cycles.
// Optional input "hold" exists only when NTT_SCHED_HOLD_EN is defined.
module ntt_sched #(
  parameter int unsigned BF_LAT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
`ifdef NTT_SCHED_HOLD_EN
  input  logic       hold,
`endif
  output logic       rd_en,
  output logic [7:0] rd_addr_a,
  output logic [7:0] rd_addr_b,
  output logic [6:0] w_idx,
  output logic       bf_sel,
  output logic       wr_en,
  output logic [7:0] wr_addr_a,
  output logic [7:0] wr_addr_b,
  output logic       busy,
  output logic       done
);

  localparam int unsigned PIPE       = 1 + BF_LAT;
  localparam logic [3:0]  DRAIN_LAST = 4'(PIPE - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t      state_q, state_d;
  logic [6:0]  bf_q, bf_d;
  logic [2:0]  layer_q, layer_d;
  logic [3:0]  drain_q, drain_d;
  logic        mode_q, mode_d;
  logic        rd_en_q, rd_en_d;
  logic [7:0]  addr_a_q, addr_a_d;
  logic [7:0]  addr_b_q, addr_b_d;
  logic [6:0]  w_q, w_d;
  logic        busy_q, done_q;
  logic        load, step;
  logic [7:0]  len_d, mask_d, off_d;
  logic        hold_w;
  logic [16:0] dly_q [PIPE];

`ifdef NTT_SCHED_HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  // bf_q is the butterfly currently presented (or pending, if held); w_q always tracks bf_q,
  // so a held butterfly is re-issued later with its own twiddle.
  always_comb begin
    state_d = state_q;
    bf_d    = bf_q;
    layer_d = layer_q;
    drain_d = drain_q;
    mode_d  = mode_q;
    w_d     = w_q;
    rd_en_d = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          mode_d  = mode;
          bf_d    = '0;
          layer_d = '0;
          rd_en_d = 1'b1;
          load    = 1'b1;
        end
      end
      ISSUE: begin
        if (rd_en_q && bf_q == 7'd127) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          if (rd_en_q) begin
            bf_d = bf_q + 7'd1;
            step = 1'b1;
          end
          rd_en_d = ~hold_w;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          if (layer_q == 3'd6) begin
            state_d = FIN;
          end else begin
            state_d = ISSUE;
            layer_d = layer_q + 3'd1;
            bf_d    = '0;
            rd_en_d = 1'b1;
            step    = 1'b1;
          end
        end else begin
          drain_d = drain_q + 4'd1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // len is a power of two, so group/offset split is a mask and the group part doubles.
    len_d    = mode_d ? (8'd128 >> layer_d) : (8'd2 << layer_d);
    mask_d   = len_d - 8'd1;
    off_d    = {1'b0, bf_d} & mask_d;
    addr_a_d = (({1'b0, bf_d} & ~mask_d) << 1) | off_d;
    addr_b_d = addr_a_d + len_d;

    if (load)
      w_d = mode_d ? 7'd1 : 7'd127;
    else if (step && off_d == '0)
      w_d = mode_d ? w_q + 7'd1 : w_q - 7'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bf_q     <= '0;
      layer_q  <= '0;
      drain_q  <= '0;
      mode_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      w_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bf_q    <= bf_d;
      layer_q <= layer_d;
      drain_q <= drain_d;
      mode_q  <= mode_d;
      rd_en_q <= rd_en_d;
      w_q     <= w_d;
      if (rd_en_d) begin
        addr_a_q <= addr_a_d;
        addr_b_q <= addr_b_d;
      end
      busy_q <= (state_d == ISSUE) || (state_d == DRAIN);
      done_q <= (state_d == FIN);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < PIPE; i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= {rd_en_q, addr_a_q, addr_b_q};
      for (int unsigned i = 1; i < PIPE; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr_a = addr_a_q;
  assign rd_addr_b = addr_b_q;
  assign w_idx     = w_q;
  assign bf_sel    = mode_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wr_en     = dly_q[PIPE-1][16];
  assign wr_addr_a = dly_q[PIPE-1][15:8];
  assign wr_addr_b = dly_q[PIPE-1][7:0];

endmodule

// File: tb/tb_ntt_sched.sv
// Bench for ntt_sched: cycle-level scoreboard from a run-timeline model, spec address table, run-level counts.
module tb_ntt_sched;
  localparam int BF_LAT = 3;
  localparam int PIPE   = 1 + BF_LAT;
  localparam int LSPAN  = 128 + PIPE;
  localparam int RUNLEN = 7 * LSPAN + 1;

  logic       clk = 1'b0;
  logic       rst, start, mode;
  logic       rd_en, bf_sel, wr_en, busy, done;
  logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [6:0] w_idx;
`ifdef NTT_SCHED_HOLD_EN
  logic       hold = 1'b0;
`endif

  ntt_sched #(.BF_LAT(BF_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
`ifdef NTT_SCHED_HOLD_EN
    .hold(hold),
`endif
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .w_idx(w_idx),
    .bf_sel(bf_sel), .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic en; logic [7:0] a; logic [7:0] b; } rdrec_t;
  typedef struct { bit m; int L; int bf; int a; int b; int w; } vec_t;

  int checks = 0, errors = 0;
  int cyc = 0, run_s = 0;
  bit run_act = 0, lmode = 0, last_rst = 0, sb_en = 1;
  rdrec_t hq[$];
  logic [43:0] exp_v, mask_v;

  int rd_cnt, wr_cnt, done_cnt, done_t, first_rd, busy_last, ncap, hold_rd;
  bit cap_en = 0, cap_m = 0, hold_win = 0;
  int obs_a [2][7][128];
  int obs_b [2][7][128];
  int obs_w [2][7][128];
  vec_t tbl [7];

  function automatic void geom(input bit m, input int L, input int bf,
                               output int a, output int b, output int w);
    int len, g, o;
    len = m ? (128 >> L) : (2 << L);
    g = bf / len;
    o = bf % len;
    a = (2 * len * g + o) % 256;
    b = (2 * len * g + o + len) % 256;
    w = m ? (1 << L) + g : (128 >> L) - 1 - g;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, expv);
    end
  endtask

  // Expected outputs for the cycle after edge 'cyc', from the run timeline.
  task automatic model_edge(input logic s, input logic m, input logic r);
    int t, k, L, bf, a, b, w;
    bit inrun, e_busy, e_done, e_rd;
    rdrec_t rec, wr;
    if (r) begin
      run_act = 0; lmode = 0; last_rst = 1;
      hq.delete();
    end else begin
      last_rst = 0;
      if (s && !(run_act && cyc <= run_s + RUNLEN)) begin
        run_act = 1; run_s = cyc; lmode = m;
      end
    end
    t = cyc + 1;
    k = t - run_s - 1;
    inrun  = run_act && k >= 0 && k < RUNLEN;
    e_busy = inrun && k < 7 * LSPAN;
    e_done = inrun && k == 7 * LSPAN;
    e_rd   = e_busy && (k % LSPAN) < 128;
    L  = e_busy ? k / LSPAN : 0;
    bf = e_busy ? k % LSPAN : 0;
    geom(lmode, L, bf % 128, a, b, w);
    rec = '{en: e_rd, a: 8'(a), b: 8'(b)};
    hq.push_back(rec);
    if (hq.size() > PIPE + 1) void'(hq.pop_front());
    wr = (hq.size() == PIPE + 1) ? hq[0] : '0;
    exp_v = {e_rd, 8'(a), 8'(b), 7'(w), lmode, wr.en, wr.a, wr.b, e_busy, e_done};
    if (last_rst) exp_v = '0;
    mask_v = {1'b1, {23{e_rd | last_rst}}, 2'b11, {16{wr.en | last_rst}}, 2'b11};
    cyc = t;
  endtask

  task automatic check_cycle();
    logic [43:0] act;
    act = {rd_en, rd_addr_a, rd_addr_b, w_idx, bf_sel, wr_en, wr_addr_a, wr_addr_b, busy, done};
    if (sb_en) begin
      checks++;
      if ((act & mask_v) !== (exp_v & mask_v)) begin
        errors++;
        $display("FAIL cycle%0d act=%h exp=%h", cyc, act & mask_v, exp_v & mask_v);
      end
    end
    if (rd_en === 1'b1) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
      if (hold_win) hold_rd++;
      if (cap_en && ncap < 896) begin
        obs_a[cap_m][ncap / 128][ncap % 128] = int'(rd_addr_a);
        obs_b[cap_m][ncap / 128][ncap % 128] = int'(rd_addr_b);
        obs_w[cap_m][ncap / 128][ncap % 128] = int'(w_idx);
        ncap++;
      end
    end
    if (wr_en === 1'b1) wr_cnt++;
    if (done === 1'b1) begin done_cnt++; done_t = cyc; end
    if (busy === 1'b1) busy_last = cyc;
  endtask

  task automatic step(input logic s, input logic m, input logic r);
    start = s; mode = m; rst = r;
    @(posedge clk);
    model_edge(s, m, r);
    #1;
    check_cycle();
    start = 1'b0; rst = 1'b0;
  endtask

  task automatic verify_capture(input bit m);
    int a, b, w;
    for (int L = 0; L < 7; L++)
      for (int bf = 0; bf < 128; bf++) begin
        geom(m, L, bf, a, b, w);
        if (obs_a[m][L][bf] != a || obs_b[m][L][bf] != b || obs_w[m][L][bf] != w) begin
          chk($sformatf("cap_m%0d_L%0d_bf%0d_a", m, L, bf), obs_a[m][L][bf], a);
          chk($sformatf("cap_m%0d_L%0d_bf%0d_b", m, L, bf), obs_b[m][L][bf], b);
          chk($sformatf("cap_m%0d_L%0d_bf%0d_w", m, L, bf), obs_w[m][L][bf], w);
        end else begin
          checks++;
        end
      end
  endtask

  // Full run with optional opposite-mode start in drain and optional 10-cycle hold.
  task automatic run_full(input logic m, input bit drain_kick, input bit capture, input int hold_at);
    int s0, extra;
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; done_t = -1; first_rd = -1; busy_last = -1;
    ncap = 0; hold_rd = 0; cap_en = capture; cap_m = m;
    extra = (hold_at >= 0) ? 10 : 0;
    sb_en = (hold_at < 0);
    s0 = cyc;
    step(1'b1, m, 1'b0);
    for (int n = 1; n < RUNLEN + 10 + extra; n++) begin
`ifdef NTT_SCHED_HOLD_EN
      hold = (hold_at >= 0 && n >= hold_at && n < hold_at + 10);
      hold_win = hold;
`endif
      step(drain_kick && n == 130, ~m, 1'b0);
    end
    cap_en = 0; sb_en = 1; hold_win = 0;
    chk("rd_pulses", rd_cnt, 896);
    chk("wr_pulses", wr_cnt, 896);
    chk("first_rd_offset", first_rd - s0, 1);
    chk("done_offset", done_t - s0, RUNLEN + extra);
    chk("busy_last_offset", busy_last - s0, RUNLEN - 1 + extra);
    chk("done_pulses", done_cnt, 1);
    if (hold_at >= 0) chk("rd_during_hold", hold_rd, 0);
  endtask

  initial begin
    int s0, rs_at;
    bit m;
    tbl[0] = '{1, 0, 0,   0,   128, 1};
    tbl[1] = '{1, 0, 127, 127, 255, 1};
    tbl[2] = '{1, 1, 64,  128, 192, 3};
    tbl[3] = '{1, 6, 127, 253, 255, 127};
    tbl[4] = '{0, 0, 0,   0,   2,   127};
    tbl[5] = '{0, 0, 2,   4,   6,   126};
    tbl[6] = '{0, 6, 0,   0,   128, 1};

    repeat (3) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    run_full(1'b1, 1'b0, 1'b1, -1);
    verify_capture(1'b1);
    run_full(1'b0, 1'b1, 1'b1, -1);
    verify_capture(1'b0);

    for (int i = 0; i < 7; i++) begin
      chk($sformatf("tbl%0d_a", i), obs_a[tbl[i].m][tbl[i].L][tbl[i].bf], tbl[i].a);
      chk($sformatf("tbl%0d_b", i), obs_b[tbl[i].m][tbl[i].L][tbl[i].bf], tbl[i].b);
      chk($sformatf("tbl%0d_w", i), obs_w[tbl[i].m][tbl[i].L][tbl[i].bf], tbl[i].w);
    end

    // Reset in the middle of layer 3, then a clean run.
    s0 = cyc;
    step(1'b1, 1'b1, 1'b0);
    for (int n = 1; n < 1 + 3 * LSPAN + 50; n++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    wr_cnt = 0; rd_cnt = 0;
    repeat (20) step(1'b0, 1'b0, 1'b0);
    chk("wr_after_rst", wr_cnt, 0);
    chk("rd_after_rst", rd_cnt, 0);
    run_full(1'b1, 1'b0, 1'b0, -1);

    for (int r = 0; r < 10; r++) begin
      m = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 4)) step(1'b0, 1'b0, 1'b0);
      step(1'b1, m, 1'b0);
      rs_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 930)) : -1;
      for (int n = 1; n < RUNLEN + 15; n++)
        step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), n == rs_at);
    end

`ifdef NTT_SCHED_HOLD_EN
    step(1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    run_full(1'b1, 1'b0, 1'b1, 1 + 2 * LSPAN + 20);
    verify_capture(1'b1);
    step(1'b0, 1'b0, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ntt_sched.md
NTT_SCHED -- requirements
Module: ntt_sched

Interface
REQ-001 Parameter BF_LAT, default 3, butterfly input-to-output latency in cycles (1..8).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to run a full transform.
REQ-005 mode  input  1  transform type, sampled with start: 1 = NTT, 0 = INTT.
REQ-006 rd_en  output  1  coefficient-pair read strobe to the polynomial RAM.
REQ-007 rd_addr_a / rd_addr_b  output  8 each  read addresses of the butterfly operand pair.
REQ-008 w_idx  output  7  twiddle (zeta) ROM index, valid with rd_en.
REQ-009 bf_sel  output  1  butterfly mode select: 1 = NTT, 0 = INTT.
REQ-010 wr_en  output  1  write-back strobe for the butterfly results s0/s1.
REQ-011 wr_addr_a / wr_addr_b  output  8 each  write addresses for s0 and s1.
REQ-012 busy  output  1  transform in progress.
REQ-013 done  output  1  one-cycle completion pulse.

Function
REQ-014 PIPE = 1 + BF_LAT: one RAM read cycle plus butterfly latency.
REQ-015 FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE->ISSUE on start.
- ISSUE->DRAIN after 128 issues.
- DRAIN->ISSUE after PIPE cycles if layers remain, else DRAIN->FIN.
- FIN->IDLE after one cycle.
REQ-016 A transform is 7 layers (layer 0..6) of 128 butterflies; bf counter 0..127 per layer.
REQ-017 Layer geometry, with group = bf / len and off = bf % len:
- NTT: len = 128 >> layer.
- INTT: len = 2 << layer.
- rd_addr_a = 2*len*group + off.
- rd_addr_b = rd_addr_a + len.
REQ-018 Twiddle index changes only at group boundaries and is held constant within a group.
- NTT: w_idx starts at 1 and increments per group, ending at 127.
- INTT: w_idx starts at 127 and decrements per group, ending at 1.
REQ-019 In ISSUE, rd_en = 1 every cycle, one butterfly per cycle.
REQ-020 In IDLE, DRAIN and FIN, rd_en = 0.
REQ-021 wr_en, wr_addr_a and wr_addr_b equal rd_en, rd_addr_a and rd_addr_b delayed exactly PIPE cycles through a shift register.
REQ-022 DRAIN lasts exactly PIPE cycles.
- The first read of layer L+1 occurs one cycle after the last wr_en of layer L.
- This guarantees read-after-write ordering.
REQ-023 bf_sel = mode latched at start; it is held constant for the whole run, including drain.
REQ-024 busy = 1 in ISSUE and DRAIN; otherwise 0.
REQ-025 done = 1 only in FIN.
REQ-026 start while busy or in FIN is ignored; mode is not re-sampled.
REQ-027 Timing: with start sampled at cycle 0, rd_en first rises at cycle 1, the last wr_en is at cycle 7*(128+PIPE), and done is at the following cycle.
REQ-028 Address arithmetic wraps modulo 256 by construction; it never exceeds 255.

Reset
REQ-029 rst returns the FSM to IDLE within one cycle, from any state including mid-run.
REQ-030 Values after rst:
- All outputs, counters and the delay line: 0.
- bf_sel: 0.
- Latched mode: 0.
REQ-031 In-flight writes are discarded on rst: wr_en = 0 from the cycle after rst onward.
REQ-032 start asserted in the same cycle as rst is ignored.

Configuration
REQ-033 Macro NTT_SCHED_HOLD_EN controls the hold feature.
REQ-034 With NTT_SCHED_HOLD_EN defined:
- Input port hold (1 bit) exists.
- hold = 1 in ISSUE forces rd_en = 0 and freezes bf, layer and w_idx.
- The delay line keeps advancing.
- hold has no effect in other states.
REQ-035 Without NTT_SCHED_HOLD_EN: the hold port is absent and behaviour is identical to hold = 0.

Verification
REQ-036 BF_LAT = 3, NTT start at cycle 0:
- rd_en first rises at cycle 1.
- busy falls and done pulses at cycle 925.
- Exactly 896 rd_en and 896 wr_en pulses.
REQ-037 NTT addresses:
- layer 0, bf 0: a = 0, b = 128, w = 1.
- layer 0, bf 127: a = 127, b = 255, w = 1.
- layer 1, bf 64: a = 128, b = 192, w = 3.
- layer 6, bf 127: a = 253, b = 255, w = 127.
REQ-038 INTT addresses and select:
- layer 0, bf 0: a = 0, b = 2, w = 127.
- layer 0, bf 2: a = 4, b = 6, w = 126.
- layer 6, bf 0: a = 0, b = 128, w = 1.
- bf_sel = 0 throughout.
REQ-039 rst asserted during layer 3 of a run:
- Next cycle: all outputs 0, no further wr_en.
- A new start then runs a full, correct transform.
REQ-040 start re-asserted during DRAIN with opposite mode: ignored; bf_sel unchanged; done timing unchanged.
REQ-041 With NTT_SCHED_HOLD_EN, hold held high for 10 cycles in layer 2:
- No rd_en during the hold.
- Addresses resume at the same bf.
- done is delayed by exactly 10 cycles.
